// File: rtl/shift_sequencer.sv
// Command-driven sequencer for a bidirectional shift register: accepts a shift command,
// pulses the selected strobe for the commanded number of cycles, then returns the register's contents.
module shift_sequencer #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_dir,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic [WIDTH-1:0] cmd_data,
    output logic             sr_shift_left,
    output logic             sr_shift_right,
    output logic [WIDTH-1:0] sr_data_in,
    input  logic [WIDTH-1:0] sr_data_out,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_CAPTURE,
        S_RESP
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             left_q, left_d;
    logic             right_q, right_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             busy_q, busy_d;

    // NOTE: every signal gets a hold default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        left_d      = left_q;
        right_d     = right_q;
        data_d      = data_q;
        rsp_data_d  = rsp_data_q;
        rsp_valid_d = rsp_valid_q;

        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    data_d = cmd_data;
                    cnt_d  = cmd_count;
                    if (cmd_count != '0) begin
                        left_d  = ~cmd_dir;
                        right_d = cmd_dir;
                        state_d = S_SHIFT;
                    end else begin
                        state_d = S_CAPTURE;
                    end
                end
            end
            S_SHIFT: begin
                cnt_d = cnt_q - CNT_W'(1);
                // The last strobe cycle is the one entered with the counter at 1.
                if (cnt_q == CNT_W'(1)) begin
                    left_d  = 1'b0;
                    right_d = 1'b0;
                    state_d = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                rsp_data_d  = sr_data_out;
                rsp_valid_d = 1'b1;
                state_d     = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            left_q      <= 1'b0;
            right_q     <= 1'b0;
            data_q      <= '0;
            rsp_data_q  <= '0;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            left_q      <= left_d;
            right_q     <= right_d;
            data_q      <= data_d;
            rsp_data_q  <= rsp_data_d;
            rsp_valid_q <= rsp_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign cmd_ready      = (state_q == S_IDLE);
    assign sr_shift_left  = left_q;
    assign sr_shift_right = right_q;
    assign sr_data_in     = data_q;
    assign rsp_valid      = rsp_valid_q;
    assign rsp_data       = rsp_data_q;
    assign busy           = busy_q;

endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
- Command-driven controller that sequences the 4-bit bidirectional shift register. The register is instantiated alongside this block, and this block drives its shift_left, shift_right and data_in inputs.
- Accepts a command with a valid/ready handshake: a direction, a shift count and a data word.
- Drives the matching shift strobe for exactly the commanded number of cycles.
- Then captures the register's data_out and returns it on a valid/ready response channel.
- Sits between a host/test sequencer and the shift register, so the shift controls are never driven ad hoc.

Parameters:
- WIDTH, 4, data width of the shift register and of command/response data.
- CNT_W, 4, width of the shift-count field; maximum shifts per command is 2^CNT_W-1.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset: asserted when 0, release synchronous to clk.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  high only in IDLE; a command is accepted on a rising edge where cmd_valid && cmd_ready.
- cmd_dir  input  1  0 = shift left, 1 = shift right.
- cmd_count  input  CNT_W  number of shift cycles to issue.
- cmd_data  input  WIDTH  value presented on sr_data_in for the whole operation.
- sr_shift_left  output  1  to the register's shift_left.
- sr_shift_right  output  1  to the register's shift_right.
- sr_data_in  output  WIDTH  to the register's data_in.
- sr_data_out  input  WIDTH  from the register's data_out.
- rsp_valid  output  1  response available.
- rsp_ready  input  1  response consumer ready.
- rsp_data  output  WIDTH  captured sr_data_out.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- States: IDLE, SHIFT, CAPTURE, RESP. Encoding is free.
- Reset (reset=0, asynchronous) forces:
  - state = IDLE;
  - sr_shift_left = sr_shift_right = 0;
  - sr_data_in = 0, rsp_data = 0;
  - rsp_valid = 0, busy = 0;
  - shift counter = 0.
- cmd_ready is decoded from the state (state==IDLE), so it reads 1 during and immediately after reset.
- All outputs except cmd_ready are registered.
- IDLE, command accepted at edge N:
  - latch cmd_dir, cmd_count and cmd_data; sr_data_in = cmd_data from N onward;
  - if cmd_count != 0: go to SHIFT, load counter = cmd_count, and assert the selected strobe (left if dir=0, right if dir=1) from edge N;
  - if cmd_count == 0: go directly to CAPTURE with no strobe asserted.
- SHIFT:
  - the strobe stays high for exactly cmd_count consecutive cycles, i.e. the register samples it at edges N+1 .. N+cmd_count;
  - the counter decrements each edge;
  - at the edge where the counter reaches 1, deassert the strobe and go to CAPTURE.
- CAPTURE: one cycle with both strobes low. At its closing edge: rsp_data <= sr_data_out, rsp_valid <= 1, go to RESP.
- RESP:
  - rsp_valid and rsp_data hold stable until an edge with rsp_ready=1;
  - at that edge: rsp_valid <= 0, go to IDLE;
  - cmd_ready rises the following cycle; there is no same-cycle turnaround.
- Invariants:
  - sr_shift_left && sr_shift_right is never true;
  - no strobe is asserted outside SHIFT;
  - sr_data_in changes only on command acceptance.
- Command latency with rsp_ready held high: acceptance edge to rsp_valid rising edge = cmd_count + 1 edges (1 edge when count = 0).
- cmd_valid outside IDLE is ignored and not queued; the requester must hold it.
- Reset mid-SHIFT: strobes drop immediately (asynchronously) and no response is produced. The register's own reset is separate and is not driven here.

Test Plan:
- Reset held low, then released; no command → cmd_ready=1, busy=0, both strobes 0, rsp_valid=0.
- Command dir=0, count=3, data=4'b0001 accepted at edge N:
  - sr_shift_left=1 for exactly 3 cycles, sr_shift_right=0 throughout;
  - rsp_valid rises at edge N+4;
  - rsp_data equals the bench register model's output after 3 left shifts.
- Command dir=1, count=2, data=4'b1000 → sr_shift_right high for 2 cycles; rsp_valid at N+3; rsp_data matches the model.
- Command count=0 → no strobe at any cycle; rsp_valid at N+1; rsp_data = current sr_data_out.
- rsp_ready held 0 for 5 cycles in RESP:
  - rsp_valid/rsp_data stable, cmd_ready=0, and a new cmd_valid is not accepted;
  - after rsp_ready=1, cmd_ready=1 one cycle later.
- Reset pulsed low during SHIFT of a count=10 command:
  - strobes go 0 without waiting for a clock edge, state returns to IDLE, no rsp_valid;
  - a following count=1 command completes normally.
